// File: rtl/hub75_line_fetch_if.sv
// rtl/hub75_line_fetch_if.sv - request, framebuffer and pixel-stream signals of the HUB75 line fetcher
interface hub75_line_fetch_if #(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 32,
  parameter int COLOR_BITS = 4
);
  localparam int ROW_W = $clog2(HEIGHT / 2);
  // One code beyond the last plane so an out-of-range plane can be requested (it blanks the line).
  localparam int PL_W  = $clog2(COLOR_BITS + 1);
  localparam int AW    = $clog2(WIDTH * HEIGHT);

  logic                    line_req;
  logic [ROW_W-1:0]        line_row;
  logic [PL_W-1:0]         line_plane;
  logic                    busy;
  logic                    line_done;
  logic                    fb_rd_en;
  logic [AW-1:0]           fb_addr;
  logic [3*COLOR_BITS-1:0] fb_data;
  logic                    pix_valid;
  logic                    pix_ready;
  logic [1:0]              pix_r;
  logic [1:0]              pix_g;
  logic [1:0]              pix_b;
  logic                    pix_last;

  modport master (
    input  line_req, line_row, line_plane, fb_data, pix_ready,
    output busy, line_done, fb_rd_en, fb_addr,
    output pix_valid, pix_r, pix_g, pix_b, pix_last
  );

  modport slave (
    output line_req, line_row, line_plane, fb_data, pix_ready,
    input  busy, line_done, fb_rd_en, fb_addr,
    input  pix_valid, pix_r, pix_g, pix_b, pix_last
  );
endinterface

// File: rtl/hub75_line_fetch.sv
// rtl/hub75_line_fetch.sv - fetches one HUB75 scan line from the framebuffer and streams one bit-plane as pixel pairs
module hub75_line_fetch #(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 32,
  parameter int COLOR_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  hub75_line_fetch_if.master bus
);
  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT / 2);
  localparam int PL_W  = $clog2(COLOR_BITS + 1);
  localparam int AW    = $clog2(WIDTH * HEIGHT);
  localparam int CB    = COLOR_BITS;
  localparam logic [ROW_W:0]   HALF_ROWS = (ROW_W + 1)'(HEIGHT / 2);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_TOP,
    S_RD_BOT,
    S_CAPTURE,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PL_W-1:0]  plane_q, plane_d;
  logic [3*CB-1:0]  top_q, top_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [1:0]       pr_q, pr_d;
  logic [1:0]       pg_q, pg_d;
  logic [1:0]       pb_q, pb_d;
  logic             last_col;

  // Word address of (row, col); row is one bit wider so the bottom-half row fits.
  function automatic logic [AW-1:0] word_addr(input logic [ROW_W:0] r, input logic [COL_W-1:0] c);
    return AW'(r) * AW'(WIDTH) + AW'(c);
  endfunction

  // Selected plane bit of one colour component; planes past the top bit read as 0.
  function automatic logic plane_bit(input logic [CB-1:0] comp, input logic [PL_W-1:0] p);
    return |(comp & (CB'(1) << p));
  endfunction

  assign last_col = (col_q == LAST_COL);

  // Line sequencing: two reads per column, slice the plane, then hold the pair until accepted.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    plane_d = plane_q;
    top_d   = top_q;
    addr_d  = addr_q;
    pr_d    = pr_q;
    pg_d    = pg_q;
    pb_d    = pb_q;
    case (state_q)
      S_IDLE: begin
        if (bus.line_req) begin
          row_d   = bus.line_row;
          plane_d = bus.line_plane;
          col_d   = '0;
          addr_d  = word_addr({1'b0, bus.line_row}, '0);
          state_d = S_RD_TOP;
        end
      end
      S_RD_TOP: begin
        addr_d  = word_addr({1'b0, row_q} + HALF_ROWS, col_q);
        state_d = S_RD_BOT;
      end
      S_RD_BOT: begin
        top_d   = bus.fb_data;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // Bottom word is on fb_data this cycle; slice it straight into the output pair.
        pr_d    = {plane_bit(bus.fb_data[3*CB-1:2*CB], plane_q), plane_bit(top_q[3*CB-1:2*CB], plane_q)};
        pg_d    = {plane_bit(bus.fb_data[2*CB-1:CB], plane_q), plane_bit(top_q[2*CB-1:CB], plane_q)};
        pb_d    = {plane_bit(bus.fb_data[CB-1:0], plane_q), plane_bit(top_q[CB-1:0], plane_q)};
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (bus.pix_ready) begin
          if (last_col) begin
            state_d = S_DONE;
          end else begin
            col_d   = col_q + 1'b1;
            addr_d  = word_addr({1'b0, row_q}, col_q + 1'b1);
            state_d = S_RD_TOP;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any line in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      plane_q <= '0;
      top_q   <= '0;
      addr_q  <= '0;
      pr_q    <= '0;
      pg_q    <= '0;
      pb_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      top_q   <= top_d;
      addr_q  <= addr_d;
      pr_q    <= pr_d;
      pg_q    <= pg_d;
      pb_q    <= pb_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.line_done = (state_q == S_DONE);
  assign bus.fb_rd_en  = (state_q == S_RD_TOP) || (state_q == S_RD_BOT);
  assign bus.fb_addr   = addr_q;
  assign bus.pix_valid = (state_q == S_PRESENT);
  assign bus.pix_last  = (state_q == S_PRESENT) && last_col;
  assign bus.pix_r     = pr_q;
  assign bus.pix_g     = pg_q;
  assign bus.pix_b     = pb_q;
endmodule

// File: tb/tb_hub75_line_fetch.sv
// tb/tb_hub75_line_fetch.sv - randomized self-checking bench for hub75_line_fetch
module tb_hub75_line_fetch;
  localparam int W     = 64;
  localparam int H     = 32;
  localparam int CB    = 4;
  localparam int HALF  = H / 2;
  localparam int ROW_W = $clog2(H / 2);
  localparam int PL_W  = $clog2(CB + 1);

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  hub75_line_fetch_if #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(CB)) bus ();

  hub75_line_fetch #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(CB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Framebuffer contents: r = a[3:0], g = ~a[3:0], b = a[4:1].
  function automatic logic [11:0] fb_word(input int a);
    logic [31:0] av;
    av = a;
    return {av[3:0], ~av[3:0], av[4:1]};
  endfunction

  // Framebuffer RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.fb_rd_en) bus.fb_data <= fb_word(int'(bus.fb_addr));
  end

  // Expected 2-bit pair {bottom, top} for component comp (0=r, 1=g, 2=b).
  function automatic int exp_pair(input int row, input int plane, input int col, input int comp);
    int top_c, bot_c;
    top_c = (int'(fb_word(row * W + col)) >> (CB * (2 - comp))) & 15;
    bot_c = (int'(fb_word((row + HALF) * W + col)) >> (CB * (2 - comp))) & 15;
    if (plane >= CB) return 0;
    return 2 * ((bot_c >> plane) & 1) + ((top_c >> plane) & 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.line_done, 0);
    check({tag, "_rd_en"}, bus.fb_rd_en, 0);
    check({tag, "_addr"}, bus.fb_addr, 0);
    check({tag, "_valid"}, bus.pix_valid, 0);
    check({tag, "_last"}, bus.pix_last, 0);
    check({tag, "_rgb"}, {bus.pix_r, bus.pix_g, bus.pix_b}, 0);
  endtask

  // Issue one line request and follow it to line_done (or to a planted reset at abort_col).
  task automatic run_line(input int row, input int plane, input bit rnd_ready, input int stall_col,
                          input bit pulse_req, input int abort_col, input int idle_after);
    int cyc, n_acc, n_rd, n_wait, stall_left, exp_addr;
    bit done, first_seen;
    bus.line_row   = ROW_W'(row);
    bus.line_plane = PL_W'(plane);
    bus.line_req   = 1'b1;
    @(negedge clk);
    bus.line_req = 1'b0;
    cyc = 1; n_acc = 0; n_rd = 0; n_wait = 0; stall_left = 10;
    done = 1'b0; first_seen = 1'b0;
    while (!done && cyc < 3000) begin
      check("busy_in_line", bus.busy, 1);
      if (bus.fb_rd_en) begin
        exp_addr = (n_rd % 2 == 0) ? row * W + n_rd / 2 : (row + HALF) * W + n_rd / 2;
        check("fb_addr", bus.fb_addr, exp_addr);
        check("rd_after_accept", n_rd / 2, n_acc);
        n_rd++;
      end
      if (rnd_ready) bus.pix_ready = ($urandom_range(0, 3) != 0);
      else           bus.pix_ready = 1'b1;
      if (bus.pix_valid) begin
        if (!first_seen) check("first_valid_latency", cyc, 4);
        first_seen = 1'b1;
        check("pix_r", bus.pix_r, exp_pair(row, plane, n_acc, 0));
        check("pix_g", bus.pix_g, exp_pair(row, plane, n_acc, 1));
        check("pix_b", bus.pix_b, exp_pair(row, plane, n_acc, 2));
        check("pix_last", bus.pix_last, (n_acc == W - 1) ? 1 : 0);
        if (n_acc == abort_col) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          check_all_zero("abort");
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", bus.line_done, 0);
            check("abort_idle", bus.busy, 0);
          end
          return;
        end
        if (n_acc == stall_col && stall_left > 0) begin
          bus.pix_ready = 1'b0;
          stall_left--;
        end
        if (bus.pix_ready) n_acc++;
        else               n_wait++;
      end
      if (bus.line_done) begin
        check("done_pairs", n_acc, W);
        check("done_reads", n_rd, 2 * W);
        check("done_cycle", cyc, 4 * W + 1 + n_wait);
        done = 1'b1;
      end
      if (pulse_req) begin
        bus.line_req   = ($urandom_range(0, 2) == 0);
        bus.line_row   = ROW_W'($urandom_range(0, HALF - 1));
        bus.line_plane = PL_W'($urandom_range(0, CB));
      end
      @(negedge clk);
      cyc++;
    end
    bus.line_req = 1'b0;
    if (!done) check("line_done_timeout", 0, 1);
    for (int i = 0; i < idle_after; i++) begin
      if (i > 0) @(negedge clk);
      check("idle_busy", bus.busy, 0);
      check("idle_rd_en", bus.fb_rd_en, 0);
      check("idle_valid", bus.pix_valid, 0);
      check("idle_done", bus.line_done, 0);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.line_req   = 1'b0;
    bus.line_row   = '0;
    bus.line_plane = '0;
    bus.pix_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_line(0, 0, 1'b0, -1, 1'b0, -1, 1);
    run_line(15, 3, 1'b0, -1, 1'b0, -1, 1);
    run_line(7, 1, 1'b0, 5, 1'b0, -1, 1);
    run_line(3, 2, 1'b0, -1, 1'b1, -1, 3);
    run_line(9, 4, 1'b0, -1, 1'b0, -1, 1);
    run_line(2, 0, 1'b0, -1, 1'b0, 30, 0);
    run_line(5, 1, 1'b0, -1, 1'b0, -1, 1);
    for (int k = 0; k < 6; k++) begin
      run_line($urandom_range(0, HALF - 1), $urandom_range(0, CB), 1'b1,
               ($urandom_range(0, 1) == 0) ? $urandom_range(0, W - 1) : -1,
               1'b0, -1, $urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
